mmio_keyboard: RTL and testbench

- Memory-mapped input device: the read-side counterpart of the MMIO LED output register.
- Synchronises and debounces NUM_BTN active-low push buttons, encodes the held button into a Hack key code, and holds it in a 16-bit keyboard register.
- The CPU reads that register at KBD_ADDR through the memory read mux.
- Hack keyboard semantics: the register holds the code while a key is held and reads 0 when no key is held.

---
 rtl/hack_io_pkg.sv | 23 ++
 rtl/btn_debounce.sv | 47 ++++
 rtl/mmio_keyboard.sv | 61 ++++++
 tb/tb_mmio_keyboard.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/hack_io_pkg.sv
// Shared constants for the Hack memory-mapped I/O devices: bus addresses and keyboard codes.
package hack_io_pkg;

  localparam logic [15:0] KBD_ADDR_DEFAULT = 16'h6000;
  localparam logic [15:0] LED_ADDR         = 16'h4000;

  localparam logic [15:0] KEY_NEWLINE   = 16'd128;
  localparam logic [15:0] KEY_BACKSPACE = 16'd129;
  localparam logic [15:0] KEY_LEFT      = 16'd130;
  localparam logic [15:0] KEY_UP        = 16'd131;
  localparam logic [15:0] KEY_RIGHT     = 16'd132;
  localparam logic [15:0] KEY_DOWN      = 16'd133;
  localparam logic [15:0] KEY_HOME      = 16'd134;
  localparam logic [15:0] KEY_ESC       = 16'd140;

  localparam int unsigned MAX_BTN = 8;

  // Button index -> key code; the first four are the arrow pad.
  localparam logic [15:0] KEY_CODE [MAX_BTN] = '{
    KEY_LEFT, KEY_UP, KEY_RIGHT, KEY_DOWN, KEY_NEWLINE, KEY_ESC, KEY_BACKSPACE, KEY_HOME
  };

endpackage

// File: rtl/btn_debounce.sv
// One active-low button: two-flop synchroniser followed by a stable-level debouncer.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 200000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_n_i,
  output logic pressed_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Any return to the stable level restarts the count, so short pulses never land.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_n_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pressed_o = ~stable_q;

endmodule

// File: rtl/mmio_keyboard.sv
// Hack keyboard register: debounced buttons encoded to a key code, readable at KBD_ADDR.
module mmio_keyboard
  import hack_io_pkg::*;
#(
  parameter int unsigned NUM_BTN         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 200000,
  parameter logic [15:0] KBD_ADDR        = KBD_ADDR_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_n,
  input  logic [15:0]        address,
  output logic [15:0]        rd_data,
  output logic [15:0]        kbd_code,
  output logic               key_press
);

  logic [NUM_BTN-1:0] pressed;
  logic [15:0]        code_q, code_d;
  logic               press_q, press_d;
  logic               found;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk_i    (clk),
      .rst_i    (rst),
      .btn_n_i  (btn_n[g]),
      .pressed_o(pressed[g])
    );
  end

  // Lowest-index pressed button wins.
  always_comb begin
    code_d = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      if (pressed[i] && !found) begin
        code_d = KEY_CODE[i];
        found  = 1'b1;
      end
    end
    press_d = (code_d != '0) && (code_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      code_q  <= '0;
      press_q <= 1'b0;
    end else begin
      code_q  <= code_d;
      press_q <= press_d;
    end
  end

  assign kbd_code  = code_q;
  assign key_press = press_q;
  assign rd_data   = (address == KBD_ADDR) ? code_q : 16'h0000;

endmodule

// File: tb/tb_mmio_keyboard.sv
// Scoreboard bench for mmio_keyboard with a short debounce window.
module tb_mmio_keyboard;

  localparam int unsigned NB  = 4;
  localparam int unsigned DC  = 8;
  localparam int unsigned LAT = DC + 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn_n = '1;
  logic [15:0]   address = 16'h6000;
  logic [15:0]   rd_data, kbd_code;
  logic          key_press;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [NB-1:0] btn;
    logic          rst;
    logic [15:0]   addr;
    logic [15:0]   code;
    logic          kp;
  } exp_t;

  exp_t sb[$];

  mmio_keyboard #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(DC),
    .KBD_ADDR       (16'h6000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_n    (btn_n),
    .address  (address),
    .rd_data  (rd_data),
    .kbd_code (kbd_code),
    .key_press(key_press)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(logic [NB-1:0] b, logic r, logic [15:0] a, logic [15:0] c,
                              logic k);
    exp_t e;
    e.btn = b; e.rst = r; e.addr = a; e.code = c; e.kp = k;
    return e;
  endfunction

  // Expected trajectory after a button change: old code until LAT edges, then the new one.
  task automatic push_phase(logic [NB-1:0] b, logic [15:0] old_c, logic [15:0] new_c,
                            logic strobe, int n);
    for (int k = 1; k <= n; k++) begin
      sb.push_back(mk(b, 1'b0, 16'h6000, (k >= LAT) ? new_c : old_c,
                      strobe && (k == LAT)));
    end
  endtask

  task automatic test_reset();
    exp_t e;
    int   k;
    sb.push_back(mk('1, 1'b1, 16'h6000, 16'd0, 1'b0));
    sb.push_back(mk('1, 1'b1, 16'h4000, 16'd0, 1'b0));
    for (int i = 0; i < 15; i++) sb.push_back(mk('1, 1'b0, 16'h6000, 16'd0, 1'b0));
    k = 0;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      btn_n = e.btn; rst = e.rst; address = e.addr;
      @(posedge clk); #1;
      k++;
      n_cmp += 3;
      if (kbd_code !== e.code) begin
        n_bad++; $display("FAIL reset[%0d] kbd_code got %0d want %0d", k, kbd_code, e.code);
      end
      if (key_press !== e.kp) begin
        n_bad++; $display("FAIL reset[%0d] key_press got %0b want %0b", k, key_press, e.kp);
      end
      if (rd_data !== ((e.addr == 16'h6000) ? e.code : 16'h0)) begin
        n_bad++; $display("FAIL reset[%0d] rd_data got %0d", k, rd_data);
      end
    end
  endtask

  task automatic test_press_and_glitch();
    exp_t e;
    int   k;
    push_phase(4'b1101, 16'd0, 16'd131, 1'b1, LAT + 2);
    sb.push_back(mk(4'b1101, 1'b0, 16'h4000, 16'd131, 1'b0));
    sb.push_back(mk(4'b1101, 1'b0, 16'h6000, 16'd131, 1'b0));
    push_phase(4'b1111, 16'd131, 16'd0, 1'b0, LAT + 2);
    for (int i = 0; i < 5; i++) sb.push_back(mk(4'b1110, 1'b0, 16'h6000, 16'd0, 1'b0));
    for (int i = 0; i < 20; i++) sb.push_back(mk(4'b1111, 1'b0, 16'h6000, 16'd0, 1'b0));
    k = 0;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      btn_n = e.btn; rst = e.rst; address = e.addr;
      @(posedge clk); #1;
      k++;
      n_cmp += 3;
      if (kbd_code !== e.code) begin
        n_bad++; $display("FAIL press[%0d] kbd_code got %0d want %0d", k, kbd_code, e.code);
      end
      if (key_press !== e.kp) begin
        n_bad++; $display("FAIL press[%0d] key_press got %0b want %0b", k, key_press, e.kp);
      end
      if (rd_data !== ((e.addr == 16'h6000) ? e.code : 16'h0)) begin
        n_bad++; $display("FAIL press[%0d] rd_data got %0d at %h", k, rd_data, e.addr);
      end
    end
  endtask

  task automatic test_overlap();
    exp_t e;
    int   k;
    push_phase(4'b1011, 16'd0, 16'd132, 1'b1, LAT + 2);
    push_phase(4'b1010, 16'd132, 16'd130, 1'b0, LAT + 2);
    push_phase(4'b1011, 16'd130, 16'd132, 1'b0, LAT + 2);
    k = 0;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      btn_n = e.btn; rst = e.rst; address = e.addr;
      @(posedge clk); #1;
      k++;
      n_cmp += 3;
      if (kbd_code !== e.code) begin
        n_bad++; $display("FAIL overlap[%0d] kbd_code got %0d want %0d", k, kbd_code, e.code);
      end
      if (key_press !== e.kp) begin
        n_bad++; $display("FAIL overlap[%0d] key_press got %0b want %0b", k, key_press, e.kp);
      end
      if (rd_data !== e.code) begin
        n_bad++; $display("FAIL overlap[%0d] rd_data got %0d want %0d", k, rd_data, e.code);
      end
    end
  endtask

  task automatic test_release_repress();
    exp_t e;
    int   k;
    push_phase(4'b1111, 16'd132, 16'd0, 1'b0, LAT + 2);
    push_phase(4'b0111, 16'd0, 16'd133, 1'b1, LAT + 2);
    k = 0;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      btn_n = e.btn; rst = e.rst; address = e.addr;
      @(posedge clk); #1;
      k++;
      n_cmp += 3;
      if (kbd_code !== e.code) begin
        n_bad++; $display("FAIL repress[%0d] kbd_code got %0d want %0d", k, kbd_code, e.code);
      end
      if (key_press !== e.kp) begin
        n_bad++; $display("FAIL repress[%0d] key_press got %0b want %0b", k, key_press, e.kp);
      end
      if (rd_data !== e.code) begin
        n_bad++; $display("FAIL repress[%0d] rd_data got %0d want %0d", k, rd_data, e.code);
      end
    end
  endtask

  // Button 1 joins the held button 3; reset lands when its counter has reached 5.
  task automatic test_reset_mid();
    exp_t e;
    int   k;
    push_phase(4'b0101, 16'd133, 16'd131, 1'b0, 7);
    sb.push_back(mk(4'b0101, 1'b1, 16'h6000, 16'd0, 1'b0));
    push_phase(4'b0101, 16'd0, 16'd131, 1'b1, LAT + 2);
    k = 0;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      btn_n = e.btn; rst = e.rst; address = e.addr;
      @(posedge clk); #1;
      k++;
      n_cmp += 3;
      if (kbd_code !== e.code) begin
        n_bad++; $display("FAIL rstmid[%0d] kbd_code got %0d want %0d", k, kbd_code, e.code);
      end
      if (key_press !== e.kp) begin
        n_bad++; $display("FAIL rstmid[%0d] key_press got %0b want %0b", k, key_press, e.kp);
      end
      if (rd_data !== e.code) begin
        n_bad++; $display("FAIL rstmid[%0d] rd_data got %0d want %0d", k, rd_data, e.code);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    #2;
    test_reset();
    test_press_and_glitch();
    test_overlap();
    test_release_repress();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
